// File: rtl/drop_scheduler.sv
// rtl/drop_scheduler.sv - BuildingDrops scene FSM, block spawn/fall, player lanes and collision
// Optional level input `pause` is compiled in when DROP_PAUSE_EN is defined.
module drop_scheduler #(
  parameter int TICK_DIV  = 250000,
  parameter int STEP      = 4,
  parameter int SPAWN_GAP = 40,
  parameter int FLOOR_ROW = 400,
  parameter int BLOCK_H   = 80,
  parameter int SCREEN_H  = 480,
  parameter int PARK      = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_left,
  input  logic        move_right,
`ifdef DROP_PAUSE_EN
  input  logic        pause,
`endif
  output logic [11:0] blocks,
  output logic [59:0] pos_blocks,
  output logic [1:0]  people,
  output logic [1:0]  scene,
  output logic [15:0] score,
  output logic [5:0]  active
);
  localparam int NSLOT = 6;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_GAP - 1);
  localparam logic [9:0]    STEP_V     = 10'(STEP);
  localparam logic [9:0]    PARK_V     = 10'(PARK);
  localparam logic [9:0]    SCREEN_V   = 10'(SCREEN_H);
  localparam logic [10:0]   BLOCK_V    = 11'(BLOCK_H);
  localparam logic [10:0]   FLOOR_V    = 11'(FLOOR_ROW);

  typedef enum logic [1:0] {
    SC_START = 2'd0,
    SC_RUN   = 2'd1,
    SC_END   = 2'd2
  } scene_t;

  scene_t           state_q, state_d;
  logic [1:0]       lane_q [NSLOT];
  logic [1:0]       lane_d [NSLOT];
  logic [9:0]       pos_q  [NSLOT];
  logic [9:0]       pos_d  [NSLOT];
  logic [NSLOT-1:0] act_q, act_d;
  logic [1:0]       people_q, people_d;
  logic [15:0]      score_q, score_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic [15:0]      lfsr_q;
  logic             start_q, left_q, right_q;

  logic             hold, start_edge, left_edge, right_edge, tick, collide;
  logic [9:0]       nxt_pos;
  logic [2:0]       retired;
  logic             found;
  logic [16:0]      score_sum;

`ifdef DROP_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign start_edge = start & ~start_q & ~hold;
  assign left_edge  = move_left & ~left_q;
  assign right_edge = move_right & ~right_q;
  assign tick       = (state_q == SC_RUN) && !hold && (tcnt_q == TICK_LAST);

  // Evaluated on registered state only, so a lane change counts from the next cycle.
  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (act_q[i] && (lane_q[i] == people_q) &&
          (({1'b0, pos_q[i]} + BLOCK_V) > FLOOR_V) && (pos_q[i] < SCREEN_V))
        collide = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    pos_d     = pos_q;
    act_d     = act_q;
    people_d  = people_q;
    score_d   = score_q;
    tcnt_d    = tcnt_q;
    scnt_d    = scnt_q;
    nxt_pos   = '0;
    retired   = '0;
    found     = 1'b0;
    score_sum = '0;
    unique case (state_q)
      SC_START: begin
        if (start_edge) begin
          state_d = SC_RUN;
          for (int i = 0; i < NSLOT; i++) begin
            lane_d[i] = '0;
            pos_d[i]  = PARK_V;
          end
          act_d    = '0;
          people_d = 2'd1;
          score_d  = '0;
          tcnt_d   = '0;
          scnt_d   = '0;
        end
      end
      SC_RUN: begin
        if (!hold)
          tcnt_d = tick ? '0 : tcnt_q + 1'b1;
        if (tick) begin
          for (int i = 0; i < NSLOT; i++) begin
            if (act_q[i]) begin
              nxt_pos = pos_q[i] + STEP_V;
              if (nxt_pos >= SCREEN_V) begin
                act_d[i]  = 1'b0;
                pos_d[i]  = PARK_V;
                lane_d[i] = '0;
                retired   = retired + 3'd1;
              end else begin
                pos_d[i] = nxt_pos;
              end
            end
          end
          score_sum = {1'b0, score_q} + {14'd0, retired};
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          // Free-slot search looks at act_q, so a slot retiring this tick is not reused yet.
          if (scnt_q == SPAWN_LAST) begin
            scnt_d = '0;
            for (int i = 0; i < NSLOT; i++) begin
              if (!act_q[i] && !found) begin
                found     = 1'b1;
                act_d[i]  = 1'b1;
                pos_d[i]  = '0;
                lane_d[i] = lfsr_q[1:0];
              end
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        if (!hold && !collide) begin
          if (left_edge && !right_edge && people_q != 2'd0)
            people_d = people_q - 2'd1;
          else if (right_edge && !left_edge && people_q != 2'd3)
            people_d = people_q + 2'd1;
        end
        if (collide)
          state_d = SC_END;
      end
      SC_END: begin
        if (start_edge)
          state_d = SC_START;
      end
      default: state_d = SC_START;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SC_START;
      act_q    <= '0;
      people_q <= 2'd1;
      score_q  <= '0;
      tcnt_q   <= '0;
      scnt_q   <= '0;
      lfsr_q   <= 16'hACE1;
      start_q  <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        lane_q[i] <= '0;
        pos_q[i]  <= PARK_V;
      end
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      people_q <= people_d;
      score_q  <= score_d;
      tcnt_q   <= tcnt_d;
      scnt_q   <= scnt_d;
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      start_q  <= start;
      left_q   <= move_left;
      right_q  <= move_right;
      lane_q   <= lane_d;
      pos_q    <= pos_d;
    end
  end

  always_comb begin
    blocks     = '0;
    pos_blocks = '0;
    for (int i = 0; i < NSLOT; i++) begin
      blocks[2*i +: 2]      = lane_q[i];
      pos_blocks[10*i +: 10] = pos_q[i];
    end
  end

  assign people = people_q;
  assign scene  = state_q;
  assign score  = score_q;
  assign active = act_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// tb/tb_drop_scheduler.sv - directed and randomized checks of drop_scheduler against a behavioural model
module tb_drop_scheduler;
  localparam int TD    = 4;
  localparam int STP   = 8;
  localparam int SG    = 2;
  localparam int FLOOR = 400;
  localparam int BH    = 80;
  localparam int SH    = 480;
  localparam int PARK  = 600;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic move_left = 1'b0;
  logic move_right = 1'b0;
`ifdef DROP_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic [11:0] blocks;
  logic [59:0] pos_blocks;
  logic [1:0]  people;
  logic [1:0]  scene;
  logic [15:0] score;
  logic [5:0]  active;

  drop_scheduler #(
    .TICK_DIV(TD), .STEP(STP), .SPAWN_GAP(SG), .FLOOR_ROW(FLOOR),
    .BLOCK_H(BH), .SCREEN_H(SH), .PARK(PARK)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .move_left(move_left), .move_right(move_right),
`ifdef DROP_PAUSE_EN
    .pause(pause),
`endif
    .blocks(blocks), .pos_blocks(pos_blocks), .people(people), .scene(scene),
    .score(score), .active(active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  int m_scene, m_people, m_score, m_tcnt, m_scnt;
  int m_lane [6];
  int m_pos [6];
  bit m_act [6];
  logic [15:0] m_lfsr;
  bit m_sq, m_lq, m_rq;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scene = 0; m_people = 1; m_score = 0; m_tcnt = 0; m_scnt = 0;
    for (int i = 0; i < 6; i++) begin
      m_lane[i] = 0; m_pos[i] = PARK; m_act[i] = 0;
    end
    m_lfsr = 16'hACE1;
    m_sq = 0; m_lq = 0; m_rq = 0;
  endtask

  function automatic bit pz_now();
`ifdef DROP_PAUSE_EN
    return pause;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_collide();
    for (int i = 0; i < 6; i++)
      if (m_act[i] && m_lane[i] == m_people && m_pos[i] + BH > FLOOR && m_pos[i] < SH)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit se, le, re, pz, col, tk;
    int free, nret, np;
    if (rst) begin
      model_reset();
      return;
    end
    pz  = pz_now();
    se  = start && !m_sq && !pz;
    le  = move_left && !m_lq;
    re  = move_right && !m_rq;
    col = m_collide();
    case (m_scene)
      0: if (se) begin
        m_scene = 1;
        for (int i = 0; i < 6; i++) begin
          m_lane[i] = 0; m_pos[i] = PARK; m_act[i] = 0;
        end
        m_people = 1; m_score = 0; m_tcnt = 0; m_scnt = 0;
      end
      1: begin
        tk = 0;
        if (!pz) begin
          m_tcnt++;
          if (m_tcnt == TD) begin
            m_tcnt = 0;
            tk = 1;
          end
        end
        if (tk) begin
          free = -1;
          for (int i = 0; i < 6; i++) if (!m_act[i] && free < 0) free = i;
          nret = 0;
          for (int i = 0; i < 6; i++) begin
            if (m_act[i]) begin
              np = (m_pos[i] + STP) % 1024;
              if (np >= SH) begin
                m_act[i] = 0; m_pos[i] = PARK; m_lane[i] = 0; nret++;
              end else begin
                m_pos[i] = np;
              end
            end
          end
          m_score = (m_score + nret > 65535) ? 65535 : m_score + nret;
          m_scnt++;
          if (m_scnt == SG) begin
            m_scnt = 0;
            if (free >= 0) begin
              m_act[free] = 1; m_pos[free] = 0; m_lane[free] = int'(m_lfsr[1:0]);
            end
          end
        end
        if (!pz && !col) begin
          if (le && !re && m_people > 0) m_people--;
          else if (re && !le && m_people < 3) m_people++;
        end
        if (col) m_scene = 2;
      end
      default: if (se) m_scene = 0;
    endcase
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    m_sq = start; m_lq = move_left; m_rq = move_right;
  endtask

  task automatic compare_all();
    logic [11:0] eb;
    logic [59:0] ep;
    logic [5:0]  ea;
    for (int i = 0; i < 6; i++) begin
      eb[2*i +: 2]   = 2'(m_lane[i]);
      ep[10*i +: 10] = 10'(m_pos[i]);
      ea[i]          = m_act[i];
    end
    check_eq("scene", 64'(scene), 64'(m_scene));
    check_eq("people", 64'(people), 64'(m_people));
    check_eq("score", 64'(score), 64'(m_score));
    check_eq("active", 64'(active), 64'(ea));
    check_eq("blocks", 64'(blocks), 64'(eb));
    check_eq("pos_blocks", 64'(pos_blocks), 64'(ep));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic pulse(input bit right);
    if (right) move_right = 1; else move_left = 1;
    step();
    move_right = 0; move_left = 0;
    step();
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
    logic [15:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = {x[14:0], ^(x & 16'hB400)};
    return x;
  endfunction

  // Lane of the k-th spawn of a run whose start edge is sampled while the LFSR holds lp.
  function automatic logic [1:0] spawn_lane(input logic [15:0] lp, input int k);
    logic [15:0] x;
    x = lfsr_adv(lp, TD * SG * (k + 1));
    return x[1:0];
  endfunction

  function automatic int free_lane(input logic [15:0] lp);
    bit used [4];
    logic [1:0] l;
    for (int j = 0; j < 4; j++) used[j] = 0;
    for (int k = 0; k < 6; k++) begin
      l = spawn_lane(lp, k);
      used[l] = 1;
    end
    for (int j = 3; j >= 0; j--) if (!used[j]) return j;
    return -1;
  endfunction

  initial begin
    int fl, p, tl, pause_len;
    logic [15:0] lp;
    logic [59:0] park_all;
    for (int i = 0; i < 6; i++) park_all[10*i +: 10] = 10'(PARK);

    #1 rst = 1;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_scene", 64'(scene), 64'(0));
    check_eq("rst_people", 64'(people), 64'(1));
    check_eq("rst_blocks", 64'(blocks), 64'(0));
    check_eq("rst_pos", 64'(pos_blocks), 64'(park_all));
    check_eq("rst_active", 64'(active), 64'(0));
    check_eq("rst_score", 64'(score), 64'(0));
    step(); step();
    rst = 0;
    step();

    // Run 1: pick a start cycle that leaves one lane free of the first six blocks.
    fl = -1;
    for (int w = 0; w < 200; w++) begin
      fl = free_lane(m_lfsr);
      if (fl >= 0) break;
      step();
    end
    check_eq("free_lane_found", 64'(fl >= 0), 64'(1));
    if (fl < 0) fl = 0;
    lp = m_lfsr;
    start = 1;
    step();
    p = cyc;
    check_eq("start_scene", 64'(scene), 64'(1));
    check_eq("start_people", 64'(people), 64'(1));
    check_eq("start_active", 64'(active), 64'(0));
    step();
    check_eq("start_hold1", 64'(scene), 64'(1));
    step();
    check_eq("start_hold2", 64'(scene), 64'(1));
    start = 0;
    while (cyc < p + TD * SG - 1) step();
    check_eq("no_early_spawn", 64'(active), 64'(0));
    step();
    check_eq("spawn_active0", 64'(active[0]), 64'(1));
    check_eq("spawn_pos0", 64'(pos_blocks[9:0]), 64'(0));
    check_eq("spawn_lane0", 64'(blocks[1:0]), 64'(spawn_lane(lp, 0)));
    repeat (TD) step();
    check_eq("fall_pos0", 64'(pos_blocks[9:0]), 64'(STP));

    for (int k = 0; k < 3; k++) begin
      pulse(1'b1);
      check_eq("move_right", 64'(people), 64'((k == 0) ? 2 : 3));
    end
    move_left = 1; move_right = 1;
    step();
    check_eq("move_both", 64'(people), 64'(3));
    move_left = 0; move_right = 0;
    step();
    for (int k = 0; k < 3 - fl; k++) pulse(1'b0);
    check_eq("player_free_lane", 64'(people), 64'(fl));

    for (int w = 0; w < 400 && active[0]; w++) step();
    check_eq("retire_cycle", 64'(cyc - p), 64'(TD * (SG + SH / STP)));
    check_eq("retire_active0", 64'(active[0]), 64'(0));
    check_eq("retire_pos0", 64'(pos_blocks[9:0]), 64'(PARK));
    check_eq("retire_score", 64'(score), 64'(1));
    check_eq("retire_scene", 64'(scene), 64'(1));

    // Asynchronous reset in the middle of a run.
    #2 rst = 1;
    #1;
    model_reset();
    compare_all();
    check_eq("midrst_scene", 64'(scene), 64'(0));
    check_eq("midrst_pos", 64'(pos_blocks), 64'(park_all));
    check_eq("midrst_score", 64'(score), 64'(0));
    step();
    rst = 0;
    step();

    // Run 2: stand in slot0's lane and wait for the collision.
    lp = m_lfsr;
    start = 1;
    step();
    p = cyc;
    start = 0;
    while (cyc < p + TD * SG) step();
    tl = int'(spawn_lane(lp, 0));
    check_eq("run2_spawn_lane0", 64'(blocks[1:0]), 64'(tl));
    for (int k = 0; k < 4 && m_people != tl; k++) pulse(tl > m_people);
    check_eq("run2_player_lane", 64'(people), 64'(tl));
    pause_len = 0;
`ifdef DROP_PAUSE_EN
    begin
      int snap;
      snap = m_pos[0];
      pause = 1;
      for (int k = 0; k < 20; k++) begin
        start = (k == 5);
        step();
        check_eq("pause_scene", 64'(scene), 64'(1));
      end
      start = 0;
      pause = 0;
      pause_len = 20;
      check_eq("pause_pos0", 64'(pos_blocks[9:0]), 64'(snap));
    end
`endif
    for (int w = 0; w < 600 && scene != 2'd2; w++) step();
    check_eq("collide_cycle", 64'(cyc - p), 64'(TD * (SG + (FLOOR - BH) / STP + 1) + 1 + pause_len));
    check_eq("collide_pos0", 64'(pos_blocks[9:0]), 64'(((FLOOR - BH) / STP + 1) * STP));
    repeat (20) step();
    check_eq("end_frozen_pos0", 64'(pos_blocks[9:0]), 64'(((FLOOR - BH) / STP + 1) * STP));
    check_eq("end_scene", 64'(scene), 64'(2));
    start = 1;
    step();
    check_eq("end_to_start", 64'(scene), 64'(0));
    start = 0;
    step();

    // Randomized phase against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) start = ~start;
      move_left  = ($urandom_range(0, 3) == 0);
      move_right = ($urandom_range(0, 3) == 0);
`ifdef DROP_PAUSE_EN
      if ($urandom_range(0, 31) == 0) pause = ~pause;
`endif
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
